// File: rtl/beep_pkg.sv
// Shared constants for the melody player: note codes, period table, FSM encoding
// and the four-melody ROM.
package beep_pkg;

  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_DO   = 3'd1;
  localparam logic [2:0] NOTE_RE   = 3'd2;
  localparam logic [2:0] NOTE_MI   = 3'd3;
  localparam logic [2:0] NOTE_FA   = 3'd4;
  localparam logic [2:0] NOTE_SO   = 3'd5;
  localparam logic [2:0] NOTE_LA   = 3'd6;
  localparam logic [2:0] NOTE_XI   = 3'd7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_TONE = 2'd1;
  localparam state_t ST_GAP  = 2'd2;

  // Full square-wave period in clock cycles at 50 MHz; rest has no period.
  function automatic logic [16:0] note_period(input logic [2:0] code);
    logic [16:0] p;
    case (code)
      NOTE_DO: p = 17'd95420;
      NOTE_RE: p = 17'd85034;
      NOTE_MI: p = 17'd75757;
      NOTE_FA: p = 17'd71633;
      NOTE_SO: p = 17'd63775;
      NOTE_LA: p = 17'd56818;
      NOTE_XI: p = 17'd50607;
      default: p = 17'd0;
    endcase
    return p;
  endfunction

  // Each row packs slot i at bits [3i+:3]; slots past 7 are rests.
  function automatic logic [2:0] mel(input logic [1:0] sel, input logic [3:0] idx);
    logic [23:0] row;
    case (sel)
      2'd0:    row = {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
      2'd1:    row = {3'd0, 3'd5, 3'd6, 3'd6, 3'd5, 3'd5, 3'd1, 3'd1};
      2'd2:    row = {3'd0, 3'd1, 3'd3, 3'd5, 3'd0, 3'd1, 3'd3, 3'd5};
      default: row = {3'd0, 3'd0, 3'd0, 3'd7, 3'd0, 3'd7, 3'd0, 3'd7};
    endcase
    return idx[3] ? NOTE_REST : row[5'(idx[2:0]) * 5'd3 +: 3];
  endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Square-wave generator: looks up the note period and toggles a registered
// 50%-duty beep while enabled; idles cleared otherwise.
module beep_tone_gen
  import beep_pkg::*;
#(
  parameter int PER_SHIFT = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       en,
  input  logic [2:0] code,
  output logic       beep
);

  logic [16:0] per;
  logic [16:0] half;
  logic [16:0] tone_cnt_q, tone_cnt_d;
  logic        beep_q, beep_d;

  assign per  = note_period(code) >> PER_SHIFT;
  assign half = per >> 1;

  always_comb begin
    tone_cnt_d = '0;
    beep_d     = 1'b0;
    if (en) begin
      beep_d = (tone_cnt_q < half) && (code != NOTE_REST);
      // Wrap test written as cnt+1 >= per so a degenerate period of 0 still wraps.
      if ({1'b0, tone_cnt_q} + 18'd1 >= {1'b0, per}) tone_cnt_d = '0;
      else                                           tone_cnt_d = tone_cnt_q + 17'd1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tone_cnt_q <= '0;
      beep_q     <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      beep_q     <= beep_d;
    end
  end

  assign beep = beep_q;

endmodule

// File: rtl/beep_seq_player.sv
// Melody sequencer: IDLE/TONE/GAP FSM stepping through SEQ_LEN note slots of
// the selected melody, with loop, abort and done-pulse handling.
module beep_seq_player
  import beep_pkg::*;
#(
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int SEQ_LEN     = 8,
  parameter int PER_SHIFT   = 0,
  parameter int DUR_W       = 26
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [1:0] seq_sel,
  input  logic       loop_en,
  input  logic       stop,
  output logic       beep,
  output logic       busy,
  output logic       done,
  output logic [3:0] note_idx
);

  localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [3:0]       IDX_LAST  = 4'(SEQ_LEN - 1);
  localparam bit               HAS_GAP   = (GAP_CYCLES > 0);

  state_t           state_q, state_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [3:0]       idx_q, idx_d;
  logic [1:0]       sel_q, sel_d;
  logic             loop_q, loop_d;
  logic             done_q, done_d;

  logic             note_last;
  logic             tone_en;
  logic [2:0]       code;

  assign note_last = (dur_q == NOTE_LAST);
  assign code      = mel(sel_q, idx_q);
  // Drop enable on the final note cycle so the tone counter and beep clear on
  // the same edge that leaves TONE.
  assign tone_en   = (state_q == ST_TONE) && !stop && !note_last;

  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          sel_d   = seq_sel;
          loop_d  = loop_en;
          idx_d   = '0;
          dur_d   = '0;
          state_d = ST_TONE;
        end
      end
      ST_TONE, ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
          dur_d   = '0;
          idx_d   = '0;
        end else if ((state_q == ST_TONE) && !note_last) begin
          dur_d = dur_q + 1'b1;
        end else if ((state_q == ST_GAP) && (dur_q != GAP_LAST)) begin
          dur_d = dur_q + 1'b1;
        end else if ((state_q == ST_TONE) && HAS_GAP) begin
          dur_d   = '0;
          state_d = ST_GAP;
        end else begin
          // Slot finished: advance to next slot, wrap on loop, or complete.
          dur_d = '0;
          if (idx_q < IDX_LAST) begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_TONE;
          end else if (loop_q) begin
            idx_d   = '0;
            state_d = ST_TONE;
          end else begin
            idx_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        dur_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      dur_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

  beep_tone_gen #(.PER_SHIFT(PER_SHIFT)) u_tone (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (tone_en),
    .code    (code),
    .beep    (beep)
  );

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_beep_seq_player.sv
// Directed bench: two builds (20-cycle gap and no gap) with short note slots,
// outputs recorded per cycle after start-accept and compared to hand-derived values.
module tb_beep_seq_player;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       start = 1'b0, start2 = 1'b0;
  logic [1:0] seq_sel = 2'd0;
  logic       loop_en = 1'b0;
  logic       stop = 1'b0, stop2 = 1'b0;
  logic       beep1, busy1, done1, beep2, busy2, done2;
  logic [3:0] idx1, idx2;

  int n_chk = 0;
  int n_fail = 0;

  bit       b1_a [0:4095];
  bit       d1_a [0:4095];
  bit       y1_a [0:4095];
  bit [3:0] i1_a [0:4095];
  bit       b2_a [0:4095];
  bit       d2_a [0:4095];
  bit       y2_a [0:4095];
  bit [3:0] i2_a [0:4095];

  always #5 sys_clk = ~sys_clk;

  beep_seq_player #(.NOTE_CYCLES(400), .GAP_CYCLES(20), .SEQ_LEN(8), .PER_SHIFT(10), .DUR_W(10)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .seq_sel(seq_sel), .loop_en(loop_en),
    .stop(stop), .beep(beep1), .busy(busy1), .done(done1), .note_idx(idx1)
  );

  beep_seq_player #(.NOTE_CYCLES(400), .GAP_CYCLES(0), .SEQ_LEN(8), .PER_SHIFT(10), .DUR_W(10)) dut_ng (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start2), .seq_sel(seq_sel), .loop_en(loop_en),
    .stop(stop2), .beep(beep2), .busy(busy2), .done(done2), .note_idx(idx2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick_rec(input int t);
    @(posedge sys_clk);
    #1;
    b1_a[t] = beep1; d1_a[t] = done1; y1_a[t] = busy1; i1_a[t] = idx1;
    b2_a[t] = beep2; d2_a[t] = done2; y2_a[t] = busy2; i2_a[t] = idx2;
  endtask

  task automatic play(input logic [1:0] sel, input logic lp);
    seq_sel = sel; loop_en = lp; start = 1'b1;
    tick_rec(0);
    start = 1'b0;
  endtask

  task automatic run_to(input int t0, input int t1);
    for (int t = t0; t <= t1; t++) tick_rec(t);
  endtask

  function automatic int cnt_hi1(input int a, input int b);
    int n = 0;
    for (int t = a; t <= b; t++) n += int'(b1_a[t]);
    return n;
  endfunction

  function automatic int cnt_done1(input int a, input int b);
    int n = 0;
    for (int t = a; t <= b; t++) n += int'(d1_a[t]);
    return n;
  endfunction

  function automatic int find1(input int from, input bit val);
    for (int t = from; t < 4096; t++) if (b1_a[t] == val) return t;
    return -1;
  endfunction

  initial begin
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    tick_rec(0);
    chk("rst_beep", beep1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_idx", idx1, 0);

    // 1: async reset mid-playback (slot 1, RE high phase)
    play(2'd0, 1'b0);
    run_to(1, 440);
    chk("t1_pre_beep", beep1, 1);
    chk("t1_pre_idx", idx1, 1);
    sys_rst = 1'b1;
    #2;
    chk("t1_rst_beep", beep1, 0);
    chk("t1_rst_busy", busy1, 0);
    chk("t1_rst_idx", idx1, 0);
    tick_rec(0);
    sys_rst = 1'b0;
    tick_rec(0);

    // 2: scale, single shot
    play(2'd0, 1'b0);
    run_to(1, 3365);
    chk("t2_busy0", y1_a[0], 1);
    chk("t2_rise1", find1(0, 1'b1), 1);
    chk("t2_fall1", find1(1, 1'b0), 47);
    chk("t2_rise2", find1(47, 1'b1), 94);
    chk("t2_hi_slot0", cnt_hi1(0, 399), 211);
    chk("t2_hi_gap0", cnt_hi1(400, 419), 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t2_idx%0d", k), i1_a[420*k], k);
      chk($sformatf("t2_idx%0d_end", k), i1_a[420*k+419], k);
    end
    chk("t2_busy_pre", y1_a[3359], 1);
    chk("t2_done_at", d1_a[3360], 1);
    chk("t2_done_cnt", cnt_done1(1, 3365), 1);
    chk("t2_busy_end", y1_a[3360], 0);
    chk("t2_idx_end", i1_a[3360], 0);

    // 3: alarm, rests silent
    play(2'd3, 1'b0);
    run_to(1, 3365);
    chk("t3_fall1", find1(1, 1'b0), 25);
    chk("t3_rise2", find1(25, 1'b1), 50);
    chk("t3_hi_slot0", cnt_hi1(0, 419), 199);
    chk("t3_hi_slot1", cnt_hi1(420, 839), 0);
    chk("t3_hi_slot2", cnt_hi1(840, 1259), 199);
    chk("t3_hi_slot3", cnt_hi1(1260, 1679), 0);
    chk("t3_hi_slot567", cnt_hi1(2100, 3365), 0);
    chk("t3_done_at", d1_a[3360], 1);

    // 4: loop, then stop in second pass while beep is high
    play(2'd1, 1'b1);
    run_to(1, 3460);
    chk("t4_idx7", i1_a[2940], 7);
    chk("t4_wrap_idx", i1_a[3360], 0);
    chk("t4_wrap_busy", y1_a[3360], 1);
    chk("t4_no_done", cnt_done1(1, 3460), 0);
    chk("t4_beep_pre", b1_a[3460], 1);
    stop = 1'b1;
    tick_rec(3461);
    stop = 1'b0;
    run_to(3462, 3470);
    chk("t4_stop_busy", y1_a[3461], 0);
    chk("t4_stop_beep", b1_a[3461], 0);
    chk("t4_stop_idx", i1_a[3461], 0);
    chk("t4_stop_done", cnt_done1(3461, 3470), 0);
    chk("t4_stop_quiet", cnt_hi1(3461, 3470), 0);

    // 5: start while busy ignored; start+stop in IDLE does nothing
    play(2'd0, 1'b0);
    run_to(1, 1299);
    seq_sel = 2'd2; loop_en = 1'b1; start = 1'b1;
    tick_rec(1300);
    start = 1'b0;
    run_to(1301, 3365);
    chk("t5_idx_slot3", i1_a[1300], 3);
    chk("t5_idx_slot4", i1_a[1680], 4);
    chk("t5_slot5_fall", find1(2101, 1'b0), 2128);
    chk("t5_done_at", d1_a[3360], 1);
    chk("t5_busy_end", y1_a[3362], 0);
    start = 1'b1; stop = 1'b1;
    tick_rec(0);
    start = 1'b0; stop = 1'b0;
    chk("t5_ss_busy", busy1, 0);
    tick_rec(1);
    chk("t5_ss_busy2", busy1, 0);

    // 6: gapless build, slots back to back every 400 cycles
    seq_sel = 2'd0; loop_en = 1'b0; start2 = 1'b1;
    tick_rec(0);
    start2 = 1'b0;
    run_to(1, 3205);
    chk("t6_idx_399", i2_a[399], 0);
    chk("t6_idx_400", i2_a[400], 1);
    chk("t6_beep_401", b2_a[401], 1);
    chk("t6_beep_400", b2_a[400], 0);
    chk("t6_idx_2800", i2_a[2800], 7);
    chk("t6_busy_pre", y2_a[3199], 1);
    chk("t6_done_at", d2_a[3200], 1);
    chk("t6_done_pre", d2_a[3199], 0);
    chk("t6_busy_end", y2_a[3200], 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/beep_seq_player.md
Name: beep_seq_player

Overview:
Parametrised successor to the single-tone beeper. On a start pulse it plays one of four stored melodies on a square-wave piezo output. Each melody is SEQ_LEN note slots. Each note sounds for a fixed duration and is followed by a silent gap. It supports single-shot and loop modes, abort, busy/done status and rest notes. It sits between the gesture/counter match logic, which drives start and seq_sel, and the buzzer pin.

Parameters:
NOTE_CYCLES, 25_000_000, clock cycles each note slot sounds (0.5 s at 50 MHz); must be >= 1
GAP_CYCLES, 2_500_000, silent cycles after each note slot; 0 = no gap
SEQ_LEN, 8, note slots per melody (2..16)
PER_SHIFT, 0, right-shift applied to every note period (simulation speed-up; 0 in silicon)
DUR_W, 26, width of duration/gap counter; must hold max(NOTE_CYCLES, GAP_CYCLES)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin playback; ignored while busy
seq_sel  in  2  melody index; sampled on accepted start
loop_en  in  1  1 = repeat melody until stop; sampled on accepted start
stop  in  1  abort playback; level or pulse
beep  out  1  square-wave buzzer drive
busy  out  1  high whenever FSM not IDLE
done  out  1  one-cycle pulse on natural completion (single-shot only)
note_idx  out  4  current slot index, 0..SEQ_LEN-1

Behaviour:
- Reset (async, immediate, including mid-playback): state IDLE, beep=0, busy=0, done=0, note_idx=0, all counters 0.
- Note codes are 3 bits. 0 = rest. 1..7 = DO RE MI FA SO LA XI with full periods 95420, 85034, 75757, 71633, 63775, 56818, 50607 cycles. Effective period P = table >> PER_SHIFT (17-bit).
- FSM states: IDLE, TONE, GAP.
- IDLE: on start=1 and stop=0:
  - latch seq_sel and loop_en;
  - note_idx=0, duration counter=0, tone counter=0;
  - go to TONE next edge.
- TONE:
  - Duration counter counts 0..NOTE_CYCLES-1.
  - Tone counter counts 0..P-1 and wraps to 0.
  - beep (registered) <= (tone_cnt < P>>1) && code!=0, i.e. 50% duty. beep first goes high on the cycle after TONE entry.
  - On the last duration cycle: clear counters and beep. Go to GAP if GAP_CYCLES>0, otherwise go directly to the advance step.
- GAP: beep=0; counts 0..GAP_CYCLES-1, then advance.
- Advance:
  - If note_idx < SEQ_LEN-1: note_idx+1, enter TONE.
  - Else if loop_en latched: note_idx=0, enter TONE.
  - Else: enter IDLE, note_idx=0, done=1 for exactly that cycle.
- stop=1 in TONE/GAP: next edge IDLE, beep=0, counters and note_idx cleared, no done pulse.
- stop and start asserted together in IDLE: stop wins, no playback.
- start while busy: ignored. No queuing, no restart.
- Changes to seq_sel/loop_en during playback have no effect.
- busy is decoded from the state register (no extra latency). done and beep are registered.
- Total single-shot length: SEQ_LEN*(NOTE_CYCLES+GAP_CYCLES) cycles from the start-accept edge to the done cycle.

Decomposition:
- Package beep_pkg holds:
  - note code constants (NOTE_REST, NOTE_DO..NOTE_XI);
  - 17-bit period table function;
  - FSM state enum;
  - melody ROM function mel(sel, idx) returning a 3-bit code. Indices >= 8 return 0.
- Melody ROM contents:
  - sel0 scale 1,2,3,4,5,6,7,0
  - sel1 1,1,5,5,6,6,5,0
  - sel2 5,3,1,0,5,3,1,0
  - sel3 alarm 7,0,7,0,7,0,0,0
- One sub-module, beep_tone_gen: takes code and enable; owns the period lookup, tone counter and registered beep. The top level holds the FSM and the duration counter.

Test Plan:
Bench parameters: NOTE_CYCLES=400, GAP_CYCLES=20, SEQ_LEN=8, PER_SHIFT=10 (DO P=93, high 46 cycles).
1. Reset mid-playback: assert sys_rst during TONE with no clock edge -> beep, busy, note_idx all 0 immediately.
2. start, seq_sel=0, loop_en=0:
   - busy=1 the cycle after start;
   - slot0 beep period 93 cycles, high 46;
   - note_idx steps 0..7 every 420 cycles;
   - done pulses once 3360 cycles after accept, then busy=0.
3. seq_sel=3 single: slots 1,3,5,6,7 rest, so beep stays 0 for whole slots; slot0 period 50607>>10=49, high 24 cycles.
4. loop_en=1, seq_sel=1:
   - after slot 7, note_idx returns to 0 with no done;
   - stop asserted mid-TONE of the second pass -> IDLE next edge, beep=0, no done.
5. Start while busy at slot 3 -> ignored, sequence unaffected. start+stop in the same IDLE cycle -> busy stays 0.
6. GAP_CYCLES=0 build -> slots back-to-back every 400 cycles, GAP never entered, done at cycle 3200.
